lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/lsu_mem_ctrl_pkg.sv | 35 +++
 rtl/lsu_mem_ctrl_align.sv | 50 +++++
 rtl/lsu_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory controller: EXU op encodings,
// funct3 size/sign codes, the controller FSM state type and a small helper
// that decides whether an access violates its natural alignment.
package lsu_mem_ctrl_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // funct3[1:0] carries the access size (00 byte, 01 half, otherwise word);
  // bytes are never misaligned.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_align: purely combinational lane handling for the memory controller.
//   funct3    - access size/sign code
//   addr_lo   - byte offset within the 32-bit word
//   wdata     - raw store data (low bytes significant)
//   rdata     - raw read word from memory
//   wmask     - byte-lane write mask for the access
//   wdata_sh  - store data moved onto its byte lanes
//   rdata_ext - loaded byte/half/word, sign- or zero-extended to 32 bits
module lsu_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_sh;
  logic        is_unsigned;

  assign is_unsigned = funct3[2];
  assign wdata_sh    = wdata << {addr_lo, 3'b000};
  // Bring the addressed lane down to bit 0 before extracting.
  assign rdata_sh    = rdata >> {addr_lo, 3'b000};

  always_comb begin
    wmask     = 4'b1111;
    rdata_ext = rdata;
    case (funct3[1:0])
      2'b00: begin
        wmask     = 4'b0001 << addr_lo;
        rdata_ext = is_unsigned ? {24'd0, rdata_sh[7:0]}
                                : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      end
      2'b01: begin
        wmask     = 4'b0011 << addr_lo;
        rdata_ext = is_unsigned ? {16'd0, rdata_sh[15:0]}
                                : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      end
      default: begin
        wmask     = 4'b1111;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: single-outstanding load/store controller between the EXU and
// a simple strobe-based memory port.
//   clk, rst                 - clock; synchronous active-low reset
//   in_valid/in_ready        - request handshake from the EXU
//   in_op, in_funct3         - operation and size/sign
//   in_addr, in_wdata        - byte address; store data or bypass value
//   mem_ren/mem_wen          - one-cycle read/write strobes
//   mem_addr/mem_wdata/mem_wmask - word address, lane data, byte mask
//   mem_rdata/mem_valid      - memory completion
//   out_valid/out_ready      - response handshake; out_data, out_err
//   dbg_state                - current FSM state for observation
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. in_ready is 1 only in IDLE. Once out_valid rises it stays 1 with
// out_data/out_err unchanged until the edge where out_ready is seen.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_err,
  output state_t      dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [1:0]    op_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q, wdata_q, res_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic          is_mem_op, misaligned, timeout_hit, is_store;
  logic [3:0]    lane_mask;
  logic [31:0]   lane_wdata, load_val;

  // Memory-side lanes are derived from the latched request so they stay
  // stable for the whole ISSUE/WAIT window regardless of the EXU inputs.
  lsu_align u_align (
    .funct3    (f3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .wmask     (lane_mask),
    .wdata_sh  (lane_wdata),
    .rdata_ext (load_val)
  );

  assign is_mem_op   = (in_op == OP_LOAD) || (in_op == OP_STORE);
  assign misaligned  = is_misaligned(in_funct3, in_addr[1:0]);
  // The count during WAIT cycle k is k-1, so this fires on the TIMEOUT-th
  // WAIT cycle; mem_valid in that same cycle still takes priority.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
  assign is_store    = (op_q == OP_STORE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = (is_mem_op && !misaligned) ? ST_ISSUE : ST_RESP;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (mem_valid || timeout_hit) state_d = ST_RESP;
      ST_RESP:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NONE;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      res_q   <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem_op) begin
              res_q <= in_wdata;
              err_q <= 1'b0;
            end else if (misaligned) begin
              res_q <= 32'd0;
              err_q <= 1'b1;
            end else begin
              op_q    <= in_op;
              f3_q    <= in_funct3;
              addr_q  <= in_addr;
              wdata_q <= in_wdata;
            end
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (mem_valid) begin
            res_q <= (op_q == OP_LOAD) ? load_val : 32'd0;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            res_q <= 32'd0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_RESP);
  assign out_data  = res_q;
  assign out_err   = err_q;
  assign mem_ren   = (state_q == ST_ISSUE) && (op_q == OP_LOAD);
  assign mem_wen   = (state_q == ST_ISSUE) && is_store;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  // Loads present an all-zero mask and data so no lane looks written.
  assign mem_wmask = {4'b0000, is_store ? lane_mask : 4'b0000};
  assign mem_wdata = is_store ? lane_wdata : 32'd0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed vector table, reset
// sequences and randomized transactions against a behavioural model.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  localparam int TB_TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        mem_ren, mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_err;
  state_t      dbg_state;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          strobe;   // 0 none, 1 read, 2 write
    logic [7:0]  wmask;
    logic [31:0] mwdata;
    logic [31:0] maddr;
    int          lat;      // sample index (cycles after accept) of out_valid
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          mem_lat;  // WAIT cycle carrying mem_valid; 0 = never
    int          rdy_lat;  // cycles out_ready is withheld in RESP
    logic [31:0] data;
    logic        err;
    int          strobe;
    logic [7:0]  wmask;
    logic [31:0] mwdata;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int mem_lat);
    exp_t e;
    int nbytes, lane;
    logic [31:0] mask, val, m;
    e = '{data: 32'd0, err: 1'b0, strobe: 0, wmask: 8'd0, mwdata: 32'd0, maddr: 32'd0, lat: 1};
    lane = int'(addr % 32'd4);
    if (op == 2'b00 || op == 2'b11) begin
      e.data = wdata;
      return e;
    end
    case (f3)
      3'b000, 3'b100: nbytes = 1;
      3'b001, 3'b101: nbytes = 2;
      default:        nbytes = 4;
    endcase
    if (lane % nbytes != 0) begin
      e.err = 1'b1;
      return e;
    end
    e.maddr  = addr - 32'(lane);
    e.strobe = (op == 2'b01) ? 1 : 2;
    if (op == 2'b10) begin
      m        = ((32'd1 << nbytes) - 32'd1) << lane;
      e.wmask  = m[7:0];
      e.mwdata = wdata << (8 * lane);
    end
    if (mem_lat >= 1 && mem_lat <= TB_TIMEOUT) begin
      e.lat = mem_lat + 2;
      if (op == 2'b01) begin
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        val  = (rdata >> (8 * lane)) & mask;
        if (!f3[2] && nbytes < 4 && val[8 * nbytes - 1]) val = val | ~mask;
        e.data = val;
      end
    end else begin
      e.err = 1'b1;
      e.lat = TB_TIMEOUT + 2;
    end
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " out_err"},   32'(out_err),   32'd0);
    check({tag, " out_data"},  out_data,       32'd0);
    check({tag, " mem_ren"},   32'(mem_ren),   32'd0);
    check({tag, " mem_wen"},   32'(mem_wen),   32'd0);
    check({tag, " mem_wmask"}, 32'(mem_wmask), 32'd0);
    check({tag, " mem_addr"},  mem_addr,       32'd0);
    check({tag, " mem_wdata"}, mem_wdata,      32'd0);
    check({tag, " state"},     32'(dbg_state), 32'(ST_IDLE));
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic run_txn(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int mem_lat,
                         input int rdy_lat, input exp_t e);
    int cyc, wait_idx, n_ren, n_wen, n;
    logic got, stable_ok, hold_ok;
    logic [7:0]  s_wmask;
    logic [31:0] s_maddr, s_mwdata;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_funct3 = f3; in_addr = addr; in_wdata = wdata;
    mem_rdata = rdata;
    step();
    // Scramble request inputs after acceptance: the DUT must have latched them.
    in_valid = 1'b0; in_op = 2'($urandom); in_funct3 = 3'($urandom);
    in_addr = $urandom; in_wdata = $urandom;
    cyc = 1; wait_idx = -1; got = 1'b0; n_ren = 0; n_wen = 0; stable_ok = 1'b1;
    s_wmask = 8'd0; s_maddr = 32'd0; s_mwdata = 32'd0;
    while (cyc <= 40 && !got) begin
      if (out_valid) got = 1'b1;
      else begin
        if (mem_ren) n_ren++;
        if (mem_wen) n_wen++;
        if (wait_idx >= 0) wait_idx++;
        if (mem_ren || mem_wen) begin
          wait_idx = 0; s_wmask = mem_wmask; s_maddr = mem_addr; s_mwdata = mem_wdata;
        end
        if (wait_idx >= 1 && (mem_addr !== e.maddr || mem_wmask !== e.wmask ||
            (e.strobe == 2 && mem_wdata !== e.mwdata))) stable_ok = 1'b0;
        // Outside WAIT a random mem_valid must be ignored.
        mem_valid = (wait_idx >= 1) ? (wait_idx == mem_lat) : 1'($urandom_range(0, 1));
        step();
        cyc++;
      end
    end
    mem_valid = 1'b0;
    check({tag, " out_valid_seen"}, 32'(out_valid), 32'd1);
    if (!got) begin
      out_ready = 1'b1; step(); out_ready = 1'b0;
      return;
    end
    check({tag, " latency"},  32'(cyc),     32'(e.lat));
    check({tag, " out_data"}, out_data,     e.data);
    check({tag, " out_err"},  32'(out_err), 32'(e.err));
    check({tag, " ren_count"}, 32'(n_ren), (e.strobe == 1) ? 32'd1 : 32'd0);
    check({tag, " wen_count"}, 32'(n_wen), (e.strobe == 2) ? 32'd1 : 32'd0);
    if (e.strobe != 0) begin
      check({tag, " mem_addr"},  s_maddr,       e.maddr);
      check({tag, " mem_wmask"}, 32'(s_wmask),  32'(e.wmask));
      if (e.strobe == 2) check({tag, " mem_wdata"}, s_mwdata, e.mwdata);
      check({tag, " mem_stable"}, 32'(stable_ok), 32'd1);
    end
    hold_ok = 1'b1;
    for (int i = 0; i < rdy_lat; i++) begin
      out_ready = 1'b0;
      mem_valid = 1'($urandom_range(0, 1));
      step();
      if (!out_valid || out_data !== e.data || out_err !== e.err || in_ready) hold_ok = 1'b0;
    end
    mem_valid = 1'b0;
    if (rdy_lat > 0) check({tag, " resp_hold"}, 32'(hold_ok), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " released_valid"}, 32'(out_valid), 32'd0);
    check({tag, " released_ready"}, 32'(in_ready),  32'd1);
  endtask

  // ---------------- test ----------------
  vec_t vecs[15];
  logic [2:0] f3_set[5];

  initial begin
    exp_t e;
    logic [1:0]  r_op;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    int          r_lat, r_rdy;

    //         op     f3      addr          wdata         rdata         ml rl  data          err strb wmask  mwdata        lat
    vecs[0]  = '{2'b01, 3'b000, 32'h8000_0003, 32'h0,        32'h8011_2233, 2, 0, 32'hFFFF_FF80, 0, 1, 8'h00, 32'h0,        4};
    vecs[1]  = '{2'b10, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 32'h0,        1, 1, 32'h0,        0, 2, 8'h0C, 32'hABCD_0000, 3};
    vecs[2]  = '{2'b01, 3'b010, 32'h8000_0001, 32'h0,        32'h0,        1, 0, 32'h0,        1, 0, 8'h00, 32'h0,        1};
    vecs[3]  = '{2'b01, 3'b101, 32'h8000_0000, 32'h0,        32'h1234_F00D, 0, 0, 32'h0,        1, 1, 8'h00, 32'h0,        6};
    vecs[4]  = '{2'b01, 3'b101, 32'h8000_0000, 32'h0,        32'h1234_F00D, 4, 0, 32'h0000_F00D, 0, 1, 8'h00, 32'h0,        6};
    vecs[5]  = '{2'b00, 3'b000, 32'h0,        32'hDEAD_BEEF, 32'h0,        0, 5, 32'hDEAD_BEEF, 0, 0, 8'h00, 32'h0,        1};
    vecs[6]  = '{2'b11, 3'b010, 32'h0000_0003, 32'h1234_5678, 32'h0,        0, 0, 32'h1234_5678, 0, 0, 8'h00, 32'h0,        1};
    vecs[7]  = '{2'b10, 3'b000, 32'h0000_0101, 32'h0000_00AA, 32'h0,        3, 0, 32'h0,        0, 2, 8'h02, 32'h0000_AA00, 5};
    vecs[8]  = '{2'b01, 3'b001, 32'h0000_0010, 32'h0,        32'h0000_8001, 1, 2, 32'hFFFF_8001, 0, 1, 8'h00, 32'h0,        3};
    vecs[9]  = '{2'b01, 3'b100, 32'h0000_0022, 32'h0,        32'h00C3_0000, 2, 0, 32'h0000_00C3, 0, 1, 8'h00, 32'h0,        4};
    vecs[10] = '{2'b10, 3'b010, 32'h0000_0044, 32'hCAFE_F00D, 32'h0,        4, 0, 32'h0,        0, 2, 8'h0F, 32'hCAFE_F00D, 6};
    vecs[11] = '{2'b10, 3'b001, 32'h0000_0003, 32'h0000_FFFF, 32'h0,        1, 0, 32'h0,        1, 0, 8'h00, 32'h0,        1};
    vecs[12] = '{2'b01, 3'b010, 32'h0000_0008, 32'h0,        32'h1122_3344, 2, 0, 32'h1122_3344, 0, 1, 8'h00, 32'h0,        4};
    vecs[13] = '{2'b01, 3'b010, 32'h0000_000C, 32'h0,        32'h5566_7788, 7, 0, 32'h0,        1, 1, 8'h00, 32'h0,        6};
    vecs[14] = '{2'b10, 3'b010, 32'h0000_0010, 32'h0000_0001, 32'h0,        0, 1, 32'h0,        1, 2, 8'h0F, 32'h0000_0001, 6};
    f3_set = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_funct3 = 3'b000;
    in_addr = 32'd0; in_wdata = 32'd0; mem_rdata = 32'd0; mem_valid = 1'b0;
    out_ready = 1'b0;
    step(); step();
    check_reset_vals("reset");
    rst = 1'b1;
    step();

    // Directed vector table.
    foreach (vecs[i]) begin
      e = '{data: vecs[i].data, err: vecs[i].err, strobe: vecs[i].strobe,
            wmask: vecs[i].wmask, mwdata: vecs[i].mwdata,
            maddr: vecs[i].addr & 32'hFFFF_FFFC, lat: vecs[i].lat};
      run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].f3, vecs[i].addr,
              vecs[i].wdata, vecs[i].rdata, vecs[i].mem_lat, vecs[i].rdy_lat, e);
    end

    // Reset while waiting on memory, then a late mem_valid pulse.
    in_valid = 1'b1; in_op = OP_LOAD; in_funct3 = F3_HU; in_addr = 32'h8000_0000;
    step();
    in_valid = 1'b0;
    step(); step();
    check("midwait state", 32'(dbg_state), 32'(ST_WAIT));
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_reset_vals("rst_wait");
    mem_rdata = 32'hFFFF_FFFF; mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_wait late_valid%0d", i), 32'(out_valid), 32'd0);
      step();
    end
    check_reset_vals("rst_wait_after");

    // Randomized transactions against the model.
    for (int i = 0; i < 150; i++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_f3    = f3_set[$urandom_range(0, 4)];
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_lat   = $urandom_range(0, 6);
      r_rdy   = $urandom_range(0, 2);
      e = model(r_op, r_f3, r_addr, r_wdata, r_rdata, r_lat);
      run_txn($sformatf("rnd%0d", i), r_op, r_f3, r_addr, r_wdata, r_rdata, r_lat, r_rdy, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
